// File: rtl/cipher_io_pkg.sv
// Definitions shared by the cipher output stages: UART frame constants and FSM state type.
package cipher_io_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/cipher_uart_tx_if.sv
// Valid/ready byte stream from the cipher coder into the UART transmitter.
interface cipher_uart_tx_if;
  import cipher_io_pkg::*;

  logic                      valid;
  logic [UART_DATA_BITS-1:0] data;
  logic                      ready;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/cipher_uart_tx_byte_fifo.sv
// Show-ahead byte FIFO with synchronous flush; a full FIFO rejects pushes even when popping.
module byte_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; entries are only read after a push has written them.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cipher_uart_tx.sv
// Buffers ciphertext bytes and serialises them as 8N1 frames on a registered, idle-high tx pin.
module cipher_uart_tx
  import cipher_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  cipher_uart_tx_if.slave  in_bus,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);

  localparam int                  BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]          LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_state_t               state, state_nx;
  logic [BAUD_W-1:0]         baud_cnt, baud_nx;
  logic [2:0]                bit_idx, bit_nx;
  logic [UART_DATA_BITS-1:0] shift, shift_nx;
  logic                      tx_nx;
  logic                      pop;
  logic                      baud_done;
  logic [7:0]                fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (in_bus.valid && in_bus.ready),
    .din   (in_bus.data),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_bus.ready = !fifo_full;
  assign busy         = (state != IDLE);
  assign baud_done    = (baud_cnt == BAUD_LAST);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt + BAUD_W'(1);
    bit_nx   = bit_idx;
    shift_nx = shift;
    tx_nx    = tx;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        baud_nx = '0;
        tx_nx   = 1'b1;
        // A flush in progress takes precedence over starting a new frame.
        if (!fifo_empty && !clear) begin
          pop      = 1'b1;
          shift_nx = fifo_dout;
          tx_nx    = 1'b0;
          state_nx = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_nx  = '0;
          bit_nx   = '0;
          tx_nx    = shift[0];
          state_nx = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_nx = '0;
          if (bit_idx == LAST_BIT) begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end else begin
            shift_nx = shift >> 1;
            tx_nx    = shift[1];
            bit_nx   = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_nx  = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      shift    <= shift_nx;
      tx       <= tx_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear)                       overflow <= 1'b0;
    else if (in_bus.valid && !in_bus.ready) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_cipher_uart_tx.sv
// Bench for cipher_uart_tx: directed scenarios plus random traffic against a frame-timing model.
module tb_cipher_uart_tx;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       sel16;

  always #5 clk = ~clk;

  cipher_uart_tx_if bus4 ();
  cipher_uart_tx_if bus16 ();

  assign bus4.valid  = in_valid && !sel16;
  assign bus4.data   = in_data;
  assign bus16.valid = in_valid && sel16;
  assign bus16.data  = in_data;

  logic       tx4, busy4, ovf4, tx16, busy16, ovf16;
  logic [3:0] cnt4, cnt16;

  cipher_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst(rst), .clear(clear), .in_bus(bus4.slave),
    .tx(tx4), .busy(busy4), .fifo_count(cnt4), .overflow(ovf4)
  );

  cipher_uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(DEPTH)) dut16 (
    .clk(clk), .rst(rst), .clear(clear), .in_bus(bus16.slave),
    .tx(tx16), .busy(busy16), .fifo_count(cnt16), .overflow(ovf16)
  );

  logic       o_tx, o_busy, o_ovf, o_ready;
  logic [3:0] o_cnt;
  assign o_tx    = sel16 ? tx16   : tx4;
  assign o_busy  = sel16 ? busy16 : busy4;
  assign o_ovf   = sel16 ? ovf16  : ovf4;
  assign o_ready = sel16 ? bus16.ready : bus4.ready;
  assign o_cnt   = sel16 ? cnt16  : cnt4;

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, m_cyc);
  endtask

  // Reference model: byte queue plus the absolute edge at which the line becomes free.
  int         m_cyc = 0;
  int         m_cpb = 4;
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic       m_ovf;
  logic       m_active;
  int         m_start;
  int         m_free_at;
  logic [7:0] m_cur;

  task automatic model_edge();
    logic full;
    logic do_pop;
    if (rst) begin
      m_q.delete();
      m_ovf     = 1'b0;
      m_active  = 1'b0;
      m_free_at = m_cyc + 1;
    end else begin
      full   = (m_q.size() == DEPTH);
      do_pop = (m_cyc >= m_free_at) && (m_q.size() > 0) && !clear;
      if (clear) begin
        m_q.delete();
        m_ovf = 1'b0;
      end else begin
        if (do_pop) begin
          m_cur = m_q.pop_front();
          m_sent.push_back(m_cur);
          m_active  = 1'b1;
          m_start   = m_cyc;
          m_free_at = m_cyc + 10 * m_cpb + 1;
        end
        if (in_valid && !full) m_q.push_back(in_data);
        if (in_valid && full)  m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic model_busy();
    return m_active && ((m_cyc - m_start) < 10 * m_cpb);
  endfunction

  function automatic logic model_tx();
    int b;
    if (!model_busy()) return 1'b1;
    b = (m_cyc - m_start) / m_cpb;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  logic txlog[$];
  int   busy_cycles;
  int   peak_cnt;
  logic all_ready;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("fifo_count", 32'(o_cnt),   32'(m_q.size()));
    check("in_ready",   32'(o_ready), 32'(m_q.size() != DEPTH));
    check("overflow",   32'(o_ovf),   32'(m_ovf));
    check("busy",       32'(o_busy),  32'(model_busy()));
    check("tx",         32'(o_tx),    32'(model_tx()));
    txlog.push_back(o_tx);
    if (o_busy) busy_cycles++;
    if (int'(o_cnt) > peak_cnt) peak_cnt = int'(o_cnt);
    all_ready &= o_ready;
    m_cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input logic use16, input int cpb, input logic valid_during);
    sel16    = use16;
    m_cpb    = cpb;
    rst      = 1'b1;
    clear    = 1'b0;
    in_valid = valid_during;
    in_data  = 8'h55;
    run(2);
    rst      = 1'b0;
    in_valid = 1'b0;
    m_sent.delete();
  endtask

  // Line-level decoder: find start bits and sample each bit at its midpoint.
  logic [7:0] dec_q[$];
  int         dec_bad;

  task automatic decode(input int from, input int c);
    int i;
    logic [7:0] b;
    dec_q.delete();
    dec_bad = 0;
    i = from;
    while (i + 10 * c <= txlog.size()) begin
      if (txlog[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = txlog[i + c * (k + 1) + c / 2];
        if (txlog[i + 9 * c + c / 2] != 1'b1) dec_bad++;
        dec_q.push_back(b);
        i += 10 * c;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    int   idx;
    int   mark;
    int   n;
    logic exp_bits[10];

    // Reset held for two cycles with a byte offered.
    all_ready = 1'b1;
    do_reset(1'b0, 4, 1'b1);
    check("rst_tx",       32'(o_tx),    32'd1);
    check("rst_busy",     32'(o_busy),  32'd0);
    check("rst_count",    32'(o_cnt),   32'd0);
    check("rst_overflow", 32'(o_ovf),   32'd0);
    check("rst_in_ready", 32'(o_ready), 32'd1);

    // Single 0xA5 frame.
    busy_cycles = 0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    check("a5_tx_at_push", 32'(o_tx), 32'd1);
    in_valid = 1'b0;
    idx = txlog.size();
    step();
    check("a5_tx_fall", 32'(o_tx), 32'd0);
    run(48);
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++)
      check($sformatf("a5_bit%0d", i), 32'(txlog[idx + i * 4 + 2]), 32'(exp_bits[i]));
    check("a5_busy_cycles", busy_cycles, 32'd40);

    // Burst of eight bytes on consecutive cycles.
    do_reset(1'b0, 4, 1'b0);
    mark      = txlog.size();
    peak_cnt  = 0;
    all_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
    end
    in_valid = 1'b0;
    run(8 * 41 + 10);
    check("burst_peak", peak_cnt, 32'd7);
    check("burst_ready", 32'(all_ready), 32'd1);
    decode(mark, 4);
    check("burst_frames", dec_q.size(), 32'd8);
    n = (dec_q.size() < 8) ? dec_q.size() : 8;
    for (int i = 0; i < n; i++) check($sformatf("burst_byte%0d", i), 32'(dec_q[i]), 32'(i + 1));
    check("burst_stop", dec_bad, 32'd0);

    // Overflow at 16 clocks per bit.
    do_reset(1'b1, 16, 1'b0);
    mark = txlog.size();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + i);
      if (i == 9) check("ovf_ready_at_10th", 32'(o_ready), 32'd0);
      step();
    end
    in_valid = 1'b0;
    check("ovf_set", 32'(o_ovf), 32'd1);
    run(9 * 161 + 20);
    check("ovf_sticky", 32'(o_ovf), 32'd1);
    decode(mark, 16);
    check("ovf_frames", dec_q.size(), 32'd9);
    n = (dec_q.size() < 9) ? dec_q.size() : 9;
    for (int i = 0; i < n; i++) check($sformatf("ovf_byte%0d", i), 32'(dec_q[i]), 32'(8'h10 + i));

    // Flush while 0x3C is on the line with three bytes queued.
    do_reset(1'b0, 4, 1'b0);
    mark = txlog.size();
    in_valid = 1'b1;
    in_data = 8'h3C; step();
    in_data = 8'h11; step();
    in_data = 8'h22; step();
    in_data = 8'h33; step();
    in_valid = 1'b0;
    run(10);
    check("clr_queued", 32'(o_cnt), 32'd3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_count", 32'(o_cnt), 32'd0);
    check("clr_overflow", 32'(o_ovf), 32'd0);
    check("clr_frame_continues", 32'(o_busy), 32'd1);
    run(60);
    decode(mark, 4);
    check("clr_frames", dec_q.size(), 32'd1);
    if (dec_q.size() > 0) check("clr_byte", 32'(dec_q[0]), 32'h3C);
    check("clr_idle_busy", 32'(o_busy), 32'd0);
    check("clr_idle_tx", 32'(o_tx), 32'd1);

    // Reset during data bit 4 of 0xFF, with another byte queued.
    do_reset(1'b0, 4, 1'b0);
    in_valid = 1'b1;
    in_data = 8'hFF; step();
    in_data = 8'h81; step();
    in_valid = 1'b0;
    run(21);
    check("rmf_in_frame", 32'(o_busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rmf_tx", 32'(o_tx), 32'd1);
    check("rmf_busy", 32'(o_busy), 32'd0);
    mark = txlog.size();
    run(60);
    decode(mark, 4);
    check("rmf_no_frames", dec_q.size(), 32'd0);
    check("rmf_count", 32'(o_cnt), 32'd0);

    // Random traffic: dense then sparse offers, occasional flushes.
    do_reset(1'b0, 4, 1'b0);
    mark = txlog.size();
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, (i < 750) ? 3 : 40) == 0);
      in_data  = 8'($urandom);
      clear    = ($urandom_range(0, 199) == 0);
      step();
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    run(9 * 41 + 10);
    decode(mark, 4);
    check("rnd_frames", dec_q.size(), m_sent.size());
    n = (dec_q.size() < m_sent.size()) ? dec_q.size() : m_sent.size();
    for (int i = 0; i < n; i++) check("rnd_byte", 32'(dec_q[i]), 32'(m_sent[i]));
    check("rnd_stop", dec_bad, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
